shape_programmer: RTL and testbench
===================================

# shape_programmer

Head-of-chain controller for the rectangle renderer pipeline. It takes shape descriptors and clear requests from the host and serialises them into renderer program beats: `program_out=1`, `x_out` = target shape index, `y_out` = register ID, `data_out` = value. It merges these beats with the scan generator's pixel stream, inserting them only in blanking cycles, so no visible pixel is displaced. Its outputs drive `program_in/x_in/y_in/data_in` of renderer 0.

## Interface
- `NUM_SHAPES`, default 16: number of renderers in the chain; valid indices are 0..NUM_SHAPES-1 (NUM_SHAPES ≤ 4095).
- `clk` in 1: single clock; all state is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pix_active` in 1: the scan generator is in the visible region this cycle.
- `pix_x`, `pix_y` in 12: current scan coordinates.
- `pix_data` in 12: background colour.
- `cmd_valid` in 1 / `cmd_ready` out 1: shape-descriptor handshake.
- `cmd_index` in 12: target shape.
- `cmd_x`, `cmd_y` in 12: rectangle origin.
- `cmd_w` in 11: rectangle width.
- `cmd_h` in 12: rectangle height.
- `cmd_color` in 12: fill colour.
- `clr_req` in 1: request to disable all shapes; sampled only in IDLE.
- `program_out` out 1, `x_out` out 12, `y_out` out 12, `data_out` out 12: stream to the renderer chain.
- `busy` out 1: state ≠ IDLE.
- `cmd_err` out 1: one-cycle pulse when a descriptor is rejected.

## Operation
- **FSM states:** IDLE, EMIT, CLEAR.
  - `cmd_ready` = (state==IDLE) && !clr_req.
  - `busy` = (state!=IDLE).
- **IDLE, clr_req=1:** go to CLEAR with shape counter = 0. Clear wins over a simultaneous `cmd_valid`; that descriptor is not accepted.
- **IDLE, cmd_valid && cmd_ready:**
  - If `cmd_index` ≥ NUM_SHAPES: pulse `cmd_err` next cycle, drop the descriptor, stay in IDLE.
  - Otherwise latch all cmd fields, set beat counter = 0, go to EMIT.
- **Beat slot:** any cycle in EMIT or CLEAR with `pix_active`=0. In a cycle with `pix_active`=1, the pixel passes through and the counters hold.
- **EMIT beat order** (glitch-free if suspended across a visible line):
  - 0: reg 2 (width) ← 0
  - 1: reg 0 ← x
  - 2: reg 1 ← y
  - 3: reg 3 ← h
  - 4: reg 4 ← color
  - 5: reg 2 ← {1'b0, w}
  - After beat 5: return to IDLE.
- **Every EMIT beat:** `program_out`=1, `x_out`=latched index, `y_out`=reg ID, `data_out`=value.
- **CLEAR:** one beat per slot, `x_out`=i, `y_out`=2, `data_out`=0, for i = 0..NUM_SHAPES-1. After i = NUM_SHAPES-1: return to IDLE.
- **Passthrough** (non-beat cycles): `program_out`=0, `x_out`=`pix_x`, `y_out`=`pix_y`, `data_out`=`pix_data`. Any pixel input presented during a beat slot is discarded; it is blanking.
- **Reset mid-operation:** go to IDLE immediately; the partial shape stays in the renderer. The host reissues the descriptor. Renderers have no reset, so the host issues a clear after power-up.
- **Arithmetic:** beat and shape counters never wrap past their terminal values. `cmd_w` is zero-extended to 12 bits. Data values are passed unmodified.

## Timing
- All outputs are registered. The output after edge k+1 reflects inputs and state in cycle k, so pixel latency is 1 cycle.
- **Reset values:**
  - `program_out`, `x_out`, `y_out`, `data_out` = 0.
  - `cmd_err` = 0, `busy` = 0.
  - `cmd_ready` = 1, unless `clr_req`=1.
- **Acceptance in cycle k:**
  - The output after edge k+1 is a passthrough of cycle k's pixel.
  - State is EMIT from cycle k+1.
  - The first beat appears after edge k+2 if `pix_active`=0 in cycle k+1.
- **With continuous blanking:** the 6 beats appear after edges k+2..k+7; `cmd_ready`=1 again in cycle k+7.
- **Back-to-back descriptors:** minimum spacing is 7 cycles.
- **CLEAR with continuous blanking:** takes NUM_SHAPES cycles plus 1 acceptance cycle.
- **`cmd_err`:** high for exactly the cycle after rejection.

## Test plan
1. **Reset:** hold `rst_n`=0 with random inputs → all stream outputs 0, `busy`=0, `cmd_err`=0, `cmd_ready`=1; deassert → passthrough begins on the next edge.
2. **Passthrough:** `pix_active`=1, (100, 50, 0x0F0) → one cycle later `program_out`=0, `x_out`=100, `y_out`=50, `data_out`=0x0F0.
3. **Program, continuous blanking:** index 3, x=10, y=20, w=30, h=40, color=0xF00 → beats (3,2,0), (3,0,10), (3,1,20), (3,3,40), (3,4,0xF00), (3,2,30) on 6 consecutive cycles; `busy` high throughout; `cmd_ready` returns one cycle after the last beat.
4. **Suspension:** same descriptor with `pix_active`=1 for 4 cycles after beat 1 → 4 passthrough outputs, then beats 2..5 in order with no beat repeated or lost.
5. **Rejection:** `cmd_index`=16 with NUM_SHAPES=16 → single `cmd_err` pulse, no beats, `busy` stays 0.
6. **Clear priority:** NUM_SHAPES=4, `clr_req` and `cmd_valid` together → beats (0,2,0), (1,2,0), (2,2,0), (3,2,0); the descriptor is accepted only after return to IDLE. Repeat with `rst_n` pulsed after beat 1 → IDLE immediately, no further beats.

Source files
------------

// File: rtl/shape_programmer.sv
// Head-of-chain controller: turns shape descriptors and clear requests into renderer
// program beats and slots them into the scan generator's blanking cycles.
module shape_programmer #(
  parameter int NUM_SHAPES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_active,
  input  logic [11:0] pix_x,
  input  logic [11:0] pix_y,
  input  logic [11:0] pix_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_index,
  input  logic [11:0] cmd_x,
  input  logic [11:0] cmd_y,
  input  logic [10:0] cmd_w,
  input  logic [11:0] cmd_h,
  input  logic [11:0] cmd_color,
  input  logic        clr_req,
  output logic        program_out,
  output logic [11:0] x_out,
  output logic [11:0] y_out,
  output logic [11:0] data_out,
  output logic        busy,
  output logic        cmd_err
);

  localparam logic [11:0] SHAPE_LIMIT = 12'(NUM_SHAPES);
  localparam logic [11:0] SHAPE_LAST  = 12'(NUM_SHAPES - 1);
  localparam logic [2:0]  BEAT_LAST   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic [11:0] shape_q, shape_d;
  logic [11:0] idx_q, idx_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic [10:0] w_q, w_d;
  logic [11:0] h_q, h_d;
  logic [11:0] color_q, color_d;
  logic        prog_q, prog_d;
  logic [11:0] xo_q, xo_d;
  logic [11:0] yo_q, yo_d;
  logic [11:0] do_q, do_d;
  logic        err_q, err_d;

  // Width is zeroed first and restored last so a shape suspended mid-update never
  // shows a half-written rectangle.
  function automatic logic [11:0] beat_reg(input logic [2:0] b);
    case (b)
      3'd0:    beat_reg = 12'd2;
      3'd1:    beat_reg = 12'd0;
      3'd2:    beat_reg = 12'd1;
      3'd3:    beat_reg = 12'd3;
      3'd4:    beat_reg = 12'd4;
      3'd5:    beat_reg = 12'd2;
      default: beat_reg = 12'd2;
    endcase
  endfunction

  function automatic logic [11:0] beat_val(input logic [2:0]  b,
                                           input logic [11:0] x,
                                           input logic [11:0] y,
                                           input logic [10:0] w,
                                           input logic [11:0] h,
                                           input logic [11:0] c);
    case (b)
      3'd0:    beat_val = 12'd0;
      3'd1:    beat_val = x;
      3'd2:    beat_val = y;
      3'd3:    beat_val = h;
      3'd4:    beat_val = c;
      3'd5:    beat_val = {1'b0, w};
      default: beat_val = 12'd0;
    endcase
  endfunction

  assign cmd_ready   = (state_q == ST_IDLE) && !clr_req;
  assign busy        = (state_q != ST_IDLE);
  assign program_out = prog_q;
  assign x_out       = xo_q;
  assign y_out       = yo_q;
  assign data_out    = do_q;
  assign cmd_err     = err_q;

  // Next-state, counters, descriptor latch and next output beat/pixel.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    shape_d = shape_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    prog_d  = 1'b0;
    xo_d    = pix_x;
    yo_d    = pix_y;
    do_d    = pix_data;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          shape_d = 12'd0;
        end else if (cmd_valid) begin
          if (cmd_index >= SHAPE_LIMIT) begin
            err_d = 1'b1;
          end else begin
            idx_d   = cmd_index;
            x_d     = cmd_x;
            y_d     = cmd_y;
            w_d     = cmd_w;
            h_d     = cmd_h;
            color_d = cmd_color;
            beat_d  = 3'd0;
            state_d = ST_EMIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (!pix_active) begin
          prog_d = 1'b1;
          xo_d   = idx_q;
          yo_d   = beat_reg(beat_q);
          do_d   = beat_val(beat_q, x_q, y_q, w_q, h_q, color_q);
          if (beat_q == BEAT_LAST) begin
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      ST_CLEAR: begin
        if (!pix_active) begin
          prog_d = 1'b1;
          xo_d   = shape_q;
          yo_d   = 12'd2;
          do_d   = 12'd0;
          if (shape_q == SHAPE_LAST) begin
            state_d = ST_IDLE;
          end else begin
            shape_d = shape_q + 12'd1;
          end
        end else begin
          shape_d = shape_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any partial program.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= 3'd0;
      shape_q <= 12'd0;
      idx_q   <= 12'd0;
      x_q     <= 12'd0;
      y_q     <= 12'd0;
      w_q     <= 11'd0;
      h_q     <= 12'd0;
      color_q <= 12'd0;
      prog_q  <= 1'b0;
      xo_q    <= 12'd0;
      yo_q    <= 12'd0;
      do_q    <= 12'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      shape_q <= shape_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      prog_q  <= prog_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      do_q    <= do_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_shape_programmer.sv
// Scoreboard bench: a queue-of-pending-beats reference model predicts every output
// cycle; a separate monitor pops and compares after each rising edge.
module tb_shape_programmer;

  localparam int NS = 4;

  typedef struct packed {
    logic        rst;
    logic        act;
    logic [11:0] px, py, pd;
    logic        cv;
    logic [11:0] idx, x, y;
    logic [10:0] w;
    logic [11:0] h, c;
    logic        clr;
  } stim_t;

  typedef struct packed {
    logic        prog;
    logic [11:0] x, y, d;
    logic        err;
    logic        busy;
  } exp_t;

  typedef struct packed {
    logic [11:0] x, y, d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_active = 1'b0;
  logic [11:0] pix_x = 12'd0, pix_y = 12'd0, pix_data = 12'd0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_index = 12'd0, cmd_x = 12'd0, cmd_y = 12'd0;
  logic [10:0] cmd_w = 11'd0;
  logic [11:0] cmd_h = 12'd0, cmd_color = 12'd0;
  logic        clr_req = 1'b0;
  logic        program_out;
  logic [11:0] x_out, y_out, data_out;
  logic        busy, cmd_err;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t  exp_q[$];
  beat_t pending[$];

  shape_programmer #(.NUM_SHAPES(NS)) dut (
    .clk(clk), .rst_n(rst_n), .pix_active(pix_active),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .clr_req(clr_req),
    .program_out(program_out), .x_out(x_out), .y_out(y_out),
    .data_out(data_out), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  function automatic stim_t base();
    stim_t s;
    s.rst = 1'b1;
    s.act = 1'b0;
    s.px  = 12'($urandom);
    s.py  = 12'($urandom);
    s.pd  = 12'($urandom);
    s.cv  = 1'b0;
    s.idx = 12'($urandom_range(0, NS - 1));
    s.x   = 12'($urandom);
    s.y   = 12'($urandom);
    s.w   = 11'($urandom);
    s.h   = 12'($urandom);
    s.c   = 12'($urandom);
    s.clr = 1'b0;
    return s;
  endfunction

  function automatic stim_t desc(input logic [11:0] idx, x, y, input logic [10:0] w,
                                 input logic [11:0] h, c);
    stim_t s;
    s = base();
    s.cv = 1'b1; s.idx = idx; s.x = x; s.y = y; s.w = w; s.h = h; s.c = c;
    return s;
  endfunction

  function automatic beat_t mk(input logic [11:0] x, y, d);
    beat_t b;
    b.x = x; b.y = y; b.d = d;
    return b;
  endfunction

  // Apply one cycle of inputs at the falling edge and predict what follows the next rising edge.
  task automatic step(input stim_t s);
    exp_t e;
    bit idle;
    @(negedge clk);
    rst_n = s.rst; pix_active = s.act; pix_x = s.px; pix_y = s.py; pix_data = s.pd;
    cmd_valid = s.cv; cmd_index = s.idx; cmd_x = s.x; cmd_y = s.y; cmd_w = s.w;
    cmd_h = s.h; cmd_color = s.c; clr_req = s.clr;
    #1;
    if (!s.rst) begin
      pending.delete();
      idle = 1'b1;
      e = '0;
    end else begin
      idle = (pending.size() == 0);
      if (!idle && !s.act) begin
        beat_t b;
        b = pending.pop_front();
        e.prog = 1'b1; e.x = b.x; e.y = b.y; e.d = b.d;
      end else begin
        e.prog = 1'b0; e.x = s.px; e.y = s.py; e.d = s.pd;
      end
      e.err = 1'b0;
      if (idle && s.clr) begin
        for (int i = 0; i < NS; i++) pending.push_back(mk(12'(i), 12'd2, 12'd0));
      end else if (idle && s.cv) begin
        if (int'(s.idx) >= NS) begin
          e.err = 1'b1;
        end else begin
          pending.push_back(mk(s.idx, 12'd2, 12'd0));
          pending.push_back(mk(s.idx, 12'd0, s.x));
          pending.push_back(mk(s.idx, 12'd1, s.y));
          pending.push_back(mk(s.idx, 12'd3, s.h));
          pending.push_back(mk(s.idx, 12'd4, s.c));
          pending.push_back(mk(s.idx, 12'd2, {1'b0, s.w}));
        end
      end
      e.busy = (pending.size() != 0);
    end
    n_cmp++;
    if (cmd_ready !== (idle && !s.clr)) begin
      n_bad++;
      $display("FAIL cmd_ready t=%0t got %b want %b", $time, cmd_ready, idle && !s.clr);
    end
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (pending.size() != 0 && guard < 100) begin
      step(base());
      guard++;
    end
  endtask

  // Monitor: every rising edge with an outstanding prediction yields one comparison.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (program_out !== e.prog || x_out !== e.x || y_out !== e.y ||
            data_out !== e.d || cmd_err !== e.err || busy !== e.busy) begin
          n_bad++;
          $display("FAIL stream t=%0t got p=%b x=%0d y=%0d d=%h err=%b busy=%b want p=%b x=%0d y=%0d d=%h err=%b busy=%b",
                   $time, program_out, x_out, y_out, data_out, cmd_err, busy,
                   e.prog, e.x, e.y, e.d, e.err, e.busy);
        end
      end
    end
  end

  initial begin
    stim_t s;
    int guard;
    // Reset held with random inputs, then release.
    for (int i = 0; i < 4; i++) begin
      s = base(); s.rst = 1'b0; s.act = 1'($urandom); s.cv = 1'($urandom);
      s.clr = (i == 2); step(s);
    end
    // Passthrough of a visible pixel.
    s = base(); s.act = 1'b1; s.px = 12'd100; s.py = 12'd50; s.pd = 12'h0F0; step(s);
    step(base());
    // Program under continuous blanking.
    step(desc(12'd3, 12'd10, 12'd20, 11'd30, 12'd40, 12'hF00));
    for (int i = 0; i < 7; i++) step(base());
    // Suspension after beat 1.
    step(desc(12'd3, 12'd10, 12'd20, 11'd30, 12'd40, 12'hF00));
    step(base()); step(base());
    for (int i = 0; i < 4; i++) begin s = base(); s.act = 1'b1; step(s); end
    for (int i = 0; i < 5; i++) step(base());
    // Rejection at and beyond the index limit, boundary index accepted.
    step(desc(12'd4, 12'd1, 12'd2, 11'd3, 12'd4, 12'd5));
    step(base());
    step(desc(12'd16, 12'd1, 12'd2, 11'd3, 12'd4, 12'd5));
    step(desc(12'd4095, 12'd1, 12'd2, 11'h7FF, 12'd4, 12'd5));
    step(desc(12'd3, 12'hFFF, 12'hFFF, 11'h7FF, 12'hFFF, 12'hFFF));
    drain();
    // Clear wins over a simultaneous descriptor, which is then held until IDLE.
    s = desc(12'd1, 12'd7, 12'd8, 11'd9, 12'd10, 12'd11); s.clr = 1'b1; step(s);
    for (int i = 0; i < 6; i++) begin
      s = desc(12'd1, 12'd7, 12'd8, 11'd9, 12'd10, 12'd11);
      if (i == 3) s.act = 1'b1;
      step(s);
    end
    drain();
    // Clear interrupted by reset after beat 1.
    s = base(); s.clr = 1'b1; step(s);
    step(base()); step(base());
    s = base(); s.rst = 1'b0; step(s);
    for (int i = 0; i < 5; i++) step(base());
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      s = base();
      s.act = ($urandom_range(0, 2) == 0);
      s.cv  = ($urandom_range(0, 2) == 0);
      s.clr = ($urandom_range(0, 24) == 0);
      s.rst = ($urandom_range(0, 99) != 0);
      case ($urandom_range(0, 5))
        0:       s.idx = 12'(NS);
        1:       s.idx = 12'($urandom);
        default: s.idx = 12'($urandom_range(0, NS - 1));
      endcase
      step(s);
    end
    drain();
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain left=%0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
